// File: rtl/writeback_if.sv
// Memory-stage to writeback-stage bus: memory-stage results in, register-file
// write port, forwarding, stall and status out.
interface writeback_if #(
  parameter int CNT_W = 32
);
  logic             iValid;
  logic [31:0]      iMemData;
  logic [31:0]      iExuData;
  logic [4:0]       iWriteAddr;
  logic             iWriteEn;
  logic             iMemToReg;
  logic             iMemValid;
  logic             iMemReady;
  logic             iHalt;
  logic             oRegWriteEn;
  logic [4:0]       oRegWriteAddr;
  logic [31:0]      oRegWriteData;
  logic             oFwdValid;
  logic             oStall;
  logic             oHalted;
  logic             oMemError;
  logic [CNT_W-1:0] oRetireCount;

  modport master (
    output iValid, iMemData, iExuData, iWriteAddr, iWriteEn, iMemToReg,
           iMemValid, iMemReady, iHalt,
    input  oRegWriteEn, oRegWriteAddr, oRegWriteData, oFwdValid, oStall,
           oHalted, oMemError, oRetireCount
  );

  modport slave (
    input  iValid, iMemData, iExuData, iWriteAddr, iWriteEn, iMemToReg,
           iMemValid, iMemReady, iHalt,
    output oRegWriteEn, oRegWriteAddr, oRegWriteData, oFwdValid, oStall,
           oHalted, oMemError, oRetireCount
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: registers memory-stage results, drives the register
// file write port and forwarding bus, stalls on pending data-memory access.
module writeback_stage #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       iClk,
  input  logic       iReset,
  writeback_if.slave wb
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, WAIT_MEM, HALTED} state_t;

  state_t           state, state_n;
  logic [TW-1:0]    cnt, cnt_n;
  logic             capture, err_set, stall;
  logic             we_q, err_q;
  logic [4:0]       addr_q;
  logic [31:0]      data_q;
  logic [CNT_W-1:0] retire_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    err_set = 1'b0;
    stall   = 1'b0;
    case (state)
      RUN: begin
        if (wb.iValid) begin
          if (wb.iMemValid && !wb.iMemReady) begin
            stall   = 1'b1;
            state_n = WAIT_MEM;
            cnt_n   = TW'(1);
          end else begin
            capture = 1'b1;
            if (wb.iHalt) state_n = HALTED;
          end
        end
      end
      WAIT_MEM: begin
        // Ready beats timeout when both land in the same cycle.
        if (wb.iMemReady) begin
          capture = 1'b1;
          state_n = wb.iHalt ? HALTED : RUN;
          cnt_n   = '0;
        end else if (cnt >= TW'(MEM_TIMEOUT)) begin
          err_set = 1'b1;
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          stall = 1'b1;
          cnt_n = cnt + TW'(1);
        end
      end
      HALTED:  stall = 1'b1;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state    <= RUN;
      cnt      <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      retire_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      // r0 writes retire but never strobe the register file.
      we_q  <= capture && wb.iWriteEn && (wb.iWriteAddr != 5'd0);
      if (capture) begin
        addr_q   <= wb.iWriteAddr;
        data_q   <= wb.iMemToReg ? wb.iMemData : wb.iExuData;
        retire_q <= retire_q + CNT_W'(1);
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign wb.oRegWriteEn   = we_q;
  assign wb.oRegWriteAddr = addr_q;
  assign wb.oRegWriteData = data_q;
  assign wb.oFwdValid     = we_q;
  assign wb.oStall        = stall;
  assign wb.oHalted       = (state == HALTED);
  assign wb.oMemError     = err_q;
  assign wb.oRetireCount  = retire_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with MEM_TIMEOUT=4.
module tb_writeback_stage;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  writeback_if #(.CNT_W(32)) wb ();

  writeback_stage #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .iClk   (clk),
    .iReset (rst),
    .wb     (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb.iValid = 0; wb.iMemData = 0; wb.iExuData = 0; wb.iWriteAddr = 0;
    wb.iWriteEn = 0; wb.iMemToReg = 0; wb.iMemValid = 0; wb.iMemReady = 0;
    wb.iHalt = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    check("rst_we",     32'(wb.oRegWriteEn), 0);
    check("rst_data",   wb.oRegWriteData, 0);
    check("rst_halted", 32'(wb.oHalted), 0);
    check("rst_err",    32'(wb.oMemError), 0);
    check("rst_retire", wb.oRetireCount, 0);
    rst = 1'b0;

    // ALU write
    wb.iValid = 1; wb.iWriteEn = 1; wb.iWriteAddr = 5; wb.iExuData = 32'h12345678;
    #1 check("alu_stall", 32'(wb.oStall), 0);
    tick();
    check("alu_we",     32'(wb.oRegWriteEn), 1);
    check("alu_fwd",    32'(wb.oFwdValid), 1);
    check("alu_addr",   32'(wb.oRegWriteAddr), 5);
    check("alu_data",   wb.oRegWriteData, 32'h12345678);
    check("alu_retire", wb.oRetireCount, 1);
    idle();
    tick();
    check("alu_pulse",  32'(wb.oRegWriteEn), 0);

    // Load with three not-ready cycles
    wb.iValid = 1; wb.iMemValid = 1; wb.iMemToReg = 1; wb.iWriteEn = 1;
    wb.iWriteAddr = 7; wb.iMemData = 32'hDEADBEEF; wb.iExuData = 32'h1111;
    #1 check("ld_stall0", 32'(wb.oStall), 1);
    tick();
    check("ld_stall1", 32'(wb.oStall), 1);
    check("ld_nowe1",  32'(wb.oRegWriteEn), 0);
    tick();
    check("ld_stall2", 32'(wb.oStall), 1);
    wb.iMemReady = 1;
    #1 check("ld_rdy_stall", 32'(wb.oStall), 0);
    tick();
    check("ld_we",     32'(wb.oRegWriteEn), 1);
    check("ld_addr",   32'(wb.oRegWriteAddr), 7);
    check("ld_data",   wb.oRegWriteData, 32'hDEADBEEF);
    check("ld_retire", wb.oRetireCount, 2);
    idle();
    tick();
    check("ld_pulse",  32'(wb.oRegWriteEn), 0);

    // r0 write suppressed but retired
    wb.iValid = 1; wb.iWriteEn = 1; wb.iWriteAddr = 0; wb.iExuData = 32'h5;
    tick();
    check("r0_we",     32'(wb.oRegWriteEn), 0);
    check("r0_retire", wb.oRetireCount, 3);
    idle();

    // Memory timeout
    wb.iValid = 1; wb.iMemValid = 1; wb.iWriteEn = 1; wb.iWriteAddr = 9;
    wb.iExuData = 32'h99;
    #1 check("to_stall0", 32'(wb.oStall), 1);
    tick(); check("to_stall1", 32'(wb.oStall), 1);
    tick(); check("to_stall2", 32'(wb.oStall), 1);
    tick(); check("to_stall3", 32'(wb.oStall), 1);
    tick();
    check("to_stall_drop", 32'(wb.oStall), 0);
    check("to_err_pre",    32'(wb.oMemError), 0);
    idle();
    tick();
    check("to_err",    32'(wb.oMemError), 1);
    check("to_nowe",   32'(wb.oRegWriteEn), 0);
    check("to_retire", wb.oRetireCount, 3);
    wb.iValid = 1; wb.iWriteEn = 1; wb.iWriteAddr = 3; wb.iExuData = 32'hA5;
    tick();
    check("to_next_we",   32'(wb.oRegWriteEn), 1);
    check("to_next_data", wb.oRegWriteData, 32'hA5);
    check("to_sticky",    32'(wb.oMemError), 1);
    check("to_next_ret",  wb.oRetireCount, 4);
    idle();

    // Halt
    wb.iValid = 1; wb.iHalt = 1;
    tick();
    check("h_halted", 32'(wb.oHalted), 1);
    check("h_stall",  32'(wb.oStall), 1);
    check("h_retire", wb.oRetireCount, 5);
    wb.iHalt = 0; wb.iWriteEn = 1; wb.iWriteAddr = 4; wb.iExuData = 32'h44;
    tick();
    check("h_nowe",    32'(wb.oRegWriteEn), 0);
    check("h_retire2", wb.oRetireCount, 5);
    check("h_hold",    32'(wb.oHalted), 1);
    rst = 1'b1;
    #1;
    check("h_rst_halted", 32'(wb.oHalted), 0);
    check("h_rst_retire", wb.oRetireCount, 0);
    check("h_rst_err",    32'(wb.oMemError), 0);
    check("h_rst_stall",  32'(wb.oStall), 0);
    #1 rst = 1'b0;
    idle();

    // Reset during a memory wait
    wb.iValid = 1; wb.iWriteEn = 1; wb.iWriteAddr = 2; wb.iExuData = 32'h77;
    tick();
    check("rw_pre_data", wb.oRegWriteData, 32'h77);
    wb.iMemValid = 1; wb.iWriteAddr = 6;
    tick();
    check("rw_wait_stall", 32'(wb.oStall), 1);
    idle();
    rst = 1'b1;
    #1;
    check("rw_rst_data",   wb.oRegWriteData, 0);
    check("rw_rst_addr",   32'(wb.oRegWriteAddr), 0);
    check("rw_rst_retire", wb.oRetireCount, 0);
    check("rw_rst_stall",  32'(wb.oStall), 0);
    #1 rst = 1'b0;
    wb.iValid = 1; wb.iWriteEn = 1; wb.iWriteAddr = 8; wb.iExuData = 32'hCAFE;
    tick();
    check("rw_we",     32'(wb.oRegWriteEn), 1);
    check("rw_addr",   32'(wb.oRegWriteAddr), 8);
    check("rw_data",   wb.oRegWriteData, 32'hCAFE);
    check("rw_retire", wb.oRetireCount, 1);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
